// File: rtl/write_buffer_pkg.sv
// Shared defaults and the store-entry record for the CPU-to-data_mem write buffer.
// Top-level integration uses this package to size and describe the buffered store port.
package write_buffer_pkg;
    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 32;
    localparam int WB_DW    = 32;

    // One buffered store: the full byte address plus a 32-bit data word.
    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// DEPTH-way word-address compare with youngest-match select, used for store-to-load forwarding.
// Slots are visited oldest to youngest starting at head, so a later hit overrides an earlier one.
module wb_fwd_match
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int WW    = WB_AW - 2,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic             lookup_en,
    input  logic [WW-1:0]    lookup_word,
    input  logic [PW-1:0]    head,
    input  logic [PW:0]      count,
    input  logic [WW-1:0]    entry_word [DEPTH],
    input  logic [WB_DW-1:0] entry_data [DEPTH],
    output logic             hit,
    output logic [WB_DW-1:0] data
);
    logic [DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign match[gi] = (entry_word[gi] == lookup_word);
        end
    endgenerate

    always_comb begin
        logic [PW-1:0] slot;
        slot = '0;
        hit  = 1'b0;
        data = '0;
        if (lookup_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot = head + PW'(k);
                if ((PW+1)'(k) < count && match[slot]) begin
                    hit  = 1'b1;
                    data = entry_data[slot];
                end
            end
        end
    end
endmodule

// File: rtl/write_buffer.sv
// Circular store buffer between the CPU store port and data_mem, with in-order drain
// and combinational forwarding of the youngest buffered store to matching loads.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_we,
    input  logic [AW-1:0]            cpu_addr,
    input  logic [WB_DW-1:0]         cpu_wdata,
    input  logic                     cpu_re,
    output logic                     stall,
    output logic                     fwd_hit,
    output logic [WB_DW-1:0]         fwd_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [WB_DW-1:0]         mem_wdata,
    input  logic                     mem_ready,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_reg, head_next;
    logic [PW-1:0]    tail_reg, tail_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [AW-1:0]    addr_store [DEPTH];
    logic [WB_DW-1:0] data_store [DEPTH];
    logic [AW-3:0]    word_store [DEPTH];

    logic full, push, pop;

    // A full buffer refuses the store even when the head drains in the same cycle.
    assign full  = (count_reg == CW'(DEPTH));
    assign push  = cpu_we && !full;
    assign pop   = (count_reg != '0) && mem_ready;
    assign stall = cpu_we && full;

    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign mem_we    = !empty;
    assign mem_addr  = empty ? '0 : addr_store[head_reg];
    assign mem_wdata = empty ? '0 : data_store[head_reg];

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (push) begin
            tail_next = tail_reg + 1'b1;
        end
        if (pop) begin
            head_next = head_reg + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry payload is not reset: validity is defined solely by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_store[tail_reg] <= cpu_addr;
            data_store[tail_reg] <= cpu_wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            assign word_store[gi] = addr_store[gi][AW-1:2];
        end
    endgenerate

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .WW    (AW - 2),
        .PW    (PW)
    ) u_fwd_match (
        .lookup_en   (cpu_re),
        .lookup_word (cpu_addr[AW-1:2]),
        .head        (head_reg),
        .count       (count_reg),
        .entry_word  (word_store),
        .entry_data  (data_store),
        .hit         (fwd_hit),
        .data        (fwd_data)
    );
endmodule
